axi_wr_slave: RTL and testbench
===============================

Name: axi_wr_slave

Overview:
AXI4-full write-channel responder. Accepts INCR write bursts from an AXI master such as the DMA write engine, and replays each beat as a single native-interface write to a local memory or peripheral. Sits between the AXI interconnect and native-slave memories. One outstanding burst at a time.

Parameters:
ADDR_W, 32, AXI and native address width
DATA_W, 32, AXI and native data width (power of 2, >=32); beats are always full-width
ID_W, 1, AXI ID width
LEN_W, 8, AXI burst-length width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (0 = reset)
s_axi_awid  in  ID_W  write address ID
s_axi_awaddr  in  ADDR_W  burst start address
s_axi_awlen  in  LEN_W  beats minus 1
s_axi_awburst  in  2  burst type; only INCR (01) is supported
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  DATA_W  write data
s_axi_wstrb  in  DATA_W/8  byte strobes
s_axi_wlast  in  1  last beat
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bid  out  ID_W  response ID
s_axi_bresp  out  2  OKAY (00) or SLVERR (10)
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
valid  out  1  native request
address  out  ADDR_W  native byte address
wdata  out  DATA_W  native write data
wstrb  out  DATA_W/8  native strobes
ready  in  1  native acknowledge

Behaviour:
- Reset (rst==0 at posedge clk): the FSM enters IDLE and the error flag clears. Outputs:
  - awready, wready, bvalid, valid are 0.
  - bid, bresp, address are 0.
  - awready first rises the cycle after rst returns to 1.
- FSM IDLE -> DATA -> RESP -> IDLE.
- IDLE:
  - awready=1; wready=0.
  - On awvalid&awready, latch id, awlen and the aligned address (low log2(DATA_W/8) bits forced to 0).
  - Clear the beat counter.
  - Set err = (awburst != 01).
  - Go to DATA.
- DATA:
  - awready=0.
  - Normal beat:
    - valid = wvalid & ~err & |wstrb.
    - wdata and wstrb are combinational pass-through.
    - wready = ready.
  - Beat with wstrb==0: consumed in one cycle (wready=1, valid=0); no native access, since a zero strobe means read on the native bus.
  - When err is set, every beat is drained (wready=1, valid=0).
  - On each accepted beat:
    - address += DATA_W/8, modulo 2^ADDR_W.
    - Counter increments.
  - The burst ends on the beat with wlast=1, then go to RESP.
  - Length mismatch sets err:
    - wlast while counter != awlen;
    - any beat after counter == awlen without wlast (that beat is also suppressed).
- RESP:
  - bvalid=1, bid=latched id, bresp = err ? 10 : 00.
  - Hold until bready, then go to IDLE.
  - awready returns 1 on the next cycle.
- Timing and latency:
  - AW handshake at cycle N; earliest W beat at N+1.
  - bvalid asserts the cycle after the wlast beat.
  - Throughput is 1 beat/cycle while ready=1.
  - Minimum single-beat transaction is 3 cycles.
- valid stays stable until ready (inherited from AXI wvalid stability).
- Errored writes never reach the native bus, except beats already completed before a late-detected length mismatch.
- Reset mid-burst: valid drops at that edge; the partial burst is abandoned with no B response.

Optional Feature:
AXI_WR_SLAVE_4K_CHECK_EN
- Defined: in IDLE, err is also set when awaddr[11:0] + (awlen+1)*DATA_W/8 > 4096 (4 KB crossing). The whole burst is drained without native writes and answered with SLVERR.
- Undefined: no check; address increments freely across 4 KB boundaries.

Decomposition:
- Shared package axi_pkg holds:
  - burst-type constants AXI_BURST_FIXED/INCR/WRAP;
  - response constants AXI_RESP_OKAY/SLVERR;
  - the FSM state encoding.
- The address/beat counter is a natural sub-module, axi_burst_cnt, reusable by a future read responder.

Test Plan:
- Single beat: awaddr=0x100, awlen=0, wstrb=F, ready=1 -> one native write at 0x100; bresp=00; bid echoes awid=1.
- INCR burst: awaddr=0x200, awlen=3, ready toggled every other cycle -> writes at 0x200/204/208/20C in order; no beat lost or duplicated; single OKAY.
- awburst=10 (WRAP), awlen=1 -> valid never asserts; 2 beats drained; bresp=10.
- Early wlast on beat 2 with awlen=3 -> 2 native writes, then bresp=10; next AW accepted afterwards.
- Mid-burst wstrb=0 on beat 1 with awlen=2 -> native writes only at beats 0 and 2; bresp=00.
- With AXI_WR_SLAVE_4K_CHECK_EN: awaddr=0xFF8, awlen=3 -> no native writes, SLVERR. Without the macro -> 4 writes, 0xFF8 through 0x1004, OKAY.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI definitions: burst/response encodings, write-responder FSM states
// and the 4 KB crossing helper.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } wr_state_e;

  // True when a burst starting at page offset addr_lo runs past the 4 KB page.
  function automatic logic crosses_4k(input logic [11:0] addr_lo,
                                      input logic [31:0] beats,
                                      input logic [31:0] bytes);
    return (32'(addr_lo) + beats * bytes) > 32'd4096;
  endfunction

endpackage

// File: rtl/axi_wr_slave_if.sv
// AXI4 write-channel bundle (AW, W, B) between a master and the write responder.
interface axi_wr_slave_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 1,
  parameter int unsigned LEN_W  = 8
);

  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [LEN_W-1:0]    awlen;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awid, awaddr, awlen, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    output awready, wready, bid, bresp, bvalid
  );

endinterface

// File: rtl/axi_burst_cnt.sv
// Burst address/beat counter: loads a start address, then steps address and
// beat count once per accepted beat. Address wraps modulo 2^ADDR_W.
module axi_burst_cnt #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned STEP   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic [LEN_W-1:0]  cnt
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;

  // Next address/count: load has priority over increment.
  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (load) begin
      addr_d = load_addr;
      cnt_d  = '0;
    end else if (inc) begin
      addr_d = addr_q + ADDR_W'(STEP);
      cnt_d  = cnt_q + LEN_W'(1);
    end
  end

  // Counter registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr = addr_q;
  assign cnt  = cnt_q;

endmodule

// File: rtl/axi_wr_slave.sv
// AXI4 INCR write responder: replays each W beat as one native write, one
// outstanding burst at a time. Optional macro AXI_WR_SLAVE_4K_CHECK_EN rejects
// bursts crossing a 4 KB page with SLVERR.
module axi_wr_slave
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 1,
  parameter int unsigned LEN_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  axi_wr_slave_if.slave       s_axi,
  output logic                valid,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic                ready
);

  localparam int unsigned BYTES = DATA_W / 8;

  wr_state_e         state_q, state_d;
  logic              err_q, err_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              awready_q, awready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;

  logic [ADDR_W-1:0] cnt_addr;
  logic [LEN_W-1:0]  beat_cnt;
  logic              cnt_load_c, cnt_inc_c;
  logic [ADDR_W-1:0] aligned_addr_c;

  logic              aw_hs_c, in_data_c, overrun_c, drain_c, wready_c, beat_c;

  axi_burst_cnt #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W),
    .STEP   (BYTES)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load_c),
    .load_addr (aligned_addr_c),
    .inc       (cnt_inc_c),
    .addr      (cnt_addr),
    .cnt       (beat_cnt)
  );

  // Beat qualification: overrun/zero-strobe/errored beats are drained locally.
  always_comb begin
    aligned_addr_c = s_axi.awaddr & ~ADDR_W'(BYTES - 1);
    aw_hs_c        = (state_q == ST_IDLE) & s_axi.awvalid & awready_q;
    in_data_c      = (state_q == ST_DATA);
    overrun_c      = in_data_c & (beat_cnt == len_q) & ~s_axi.wlast;
    drain_c        = err_q | overrun_c | ~|s_axi.wstrb;
    wready_c       = in_data_c & (drain_c | ready);
    beat_c         = s_axi.wvalid & wready_c;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    id_d       = id_q;
    len_d      = len_q;
    awready_d  = awready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    cnt_load_c = 1'b0;
    cnt_inc_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        awready_d = 1'b1;
        if (aw_hs_c) begin
          id_d       = s_axi.awid;
          len_d      = s_axi.awlen;
          cnt_load_c = 1'b1;
          awready_d  = 1'b0;
          state_d    = ST_DATA;
`ifdef AXI_WR_SLAVE_4K_CHECK_EN
          err_d = (s_axi.awburst != AXI_BURST_INCR) |
                  crosses_4k(s_axi.awaddr[11:0], 32'(s_axi.awlen) + 32'd1, 32'(BYTES));
`else
          err_d = (s_axi.awburst != AXI_BURST_INCR);
`endif
        end
      end
      ST_DATA: begin
        awready_d = 1'b0;
        if (beat_c) begin
          cnt_inc_c = 1'b1;
          err_d     = err_q | overrun_c | (s_axi.wlast & (beat_cnt != len_q));
          if (s_axi.wlast) begin
            state_d  = ST_RESP;
            bvalid_d = 1'b1;
            bresp_d  = err_d ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          end
        end
      end
      ST_RESP: begin
        if (s_axi.bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        awready_d = 1'b0;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      err_q     <= 1'b0;
      id_q      <= '0;
      len_q     <= '0;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= AXI_RESP_OKAY;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      id_q      <= id_d;
      len_q     <= len_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_c;
  assign s_axi.bid     = id_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.bvalid  = bvalid_q;

  assign valid   = in_data_c & s_axi.wvalid & ~drain_c;
  assign address = cnt_addr;
  assign wdata   = s_axi.wdata;
  assign wstrb   = s_axi.wstrb;

endmodule

// File: tb/tb_axi_wr_slave.sv
// Directed bench for axi_wr_slave: AXI bursts in, native writes recorded and
// compared against hand-computed addresses, data and responses.
module tb_axi_wr_slave;
  import axi_pkg::*;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  int          rdy_mode;
  int          checks;
  int          errors;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [3:0]  wr_strb_q[$];

  axi_wr_slave_if #(.ADDR_W(32), .DATA_W(32), .ID_W(1), .LEN_W(8)) s_axi ();

  axi_wr_slave #(.ADDR_W(32), .DATA_W(32), .ID_W(1), .LEN_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_axi   (s_axi),
    .valid   (valid),
    .address (address),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .ready   (ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Native-side ready pattern: 0 = always ready, 1 = toggling, other = stalled.
  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       ready = 1'b1;
        1:       ready = ~ready;
        default: ready = 1'b0;
      endcase
    end
  end

  // Record every native write that completes at the coming edge.
  always @(negedge clk) begin
    if (rst && valid && ready) begin
      wr_addr_q.push_back(address);
      wr_data_q.push_back(wdata);
      wr_strb_q.push_back(wstrb);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_aw(input logic id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    int n;
    n = 0;
    s_axi.awid    = id;
    s_axi.awaddr  = addr;
    s_axi.awlen   = len;
    s_axi.awburst = burst;
    s_axi.awvalid = 1'b1;
    @(negedge clk);
    while (s_axi.awready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("aw_accept", 64'(s_axi.awready), 64'd1);
    @(posedge clk);
    #1;
    s_axi.awvalid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    int n;
    n = 0;
    s_axi.wdata  = d;
    s_axi.wstrb  = s;
    s_axi.wlast  = l;
    s_axi.wvalid = 1'b1;
    @(negedge clk);
    while (s_axi.wready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("w_accept", 64'(s_axi.wready), 64'd1);
    @(posedge clk);
    #1;
    s_axi.wvalid = 1'b0;
    s_axi.wlast  = 1'b0;
  endtask

  task automatic wait_b(input string tag, input logic id, input logic [1:0] resp);
    int n;
    n = 0;
    s_axi.bready = 1'b1;
    @(negedge clk);
    while (s_axi.bvalid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_bvalid"}, 64'(s_axi.bvalid), 64'd1);
    chk({tag, "_bid"}, 64'(s_axi.bid), 64'(id));
    chk({tag, "_bresp"}, 64'(s_axi.bresp), 64'(resp));
    @(posedge clk);
    #1;
    s_axi.bready = 1'b0;
    chk({tag, "_awready_after_b"}, 64'(s_axi.awready), 64'd1);
  endtask

  task automatic clear_writes();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_strb_q.delete();
  endtask

  initial begin
    logic [1:0] wrap_burst;
    logic [1:0] fixed_burst;
    checks        = 0;
    errors        = 0;
    rdy_mode      = 0;
    rst           = 1'b0;
    wrap_burst    = AXI_BURST_WRAP;
    fixed_burst   = AXI_BURST_FIXED;
    s_axi.awid    = '0;
    s_axi.awaddr  = '0;
    s_axi.awlen   = '0;
    s_axi.awburst = AXI_BURST_INCR;
    s_axi.awvalid = 1'b0;
    s_axi.wdata   = '0;
    s_axi.wstrb   = '0;
    s_axi.wlast   = 1'b0;
    s_axi.wvalid  = 1'b0;
    s_axi.bready  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 64'(s_axi.awready), 64'd0);
    chk("rst_wready", 64'(s_axi.wready), 64'd0);
    chk("rst_bvalid", 64'(s_axi.bvalid), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_bid", 64'(s_axi.bid), 64'd0);
    chk("rst_bresp", 64'(s_axi.bresp), 64'd0);
    chk("rst_address", 64'(address), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("awready_before_edge", 64'(s_axi.awready), 64'd0);
    @(posedge clk);
    #1;
    chk("awready_first_rise", 64'(s_axi.awready), 64'd1);

    // Single beat, id echo
    send_aw(1'b1, 32'h100, 8'd0, AXI_BURST_INCR);
    chk("t1_valid_idle_w", 64'(valid), 64'd0);
    send_beat(32'hA1A1_0001, 4'hF, 1'b1);
    chk("t1_bvalid_next_cycle", 64'(s_axi.bvalid), 64'd1);
    wait_b("t1", 1'b1, AXI_RESP_OKAY);
    chk("t1_count", 64'(wr_addr_q.size()), 64'd1);
    chk("t1_addr", 64'(wr_addr_q[0]), 64'h100);
    chk("t1_data", 64'(wr_data_q[0]), 64'hA1A1_0001);
    clear_writes();

    // INCR burst of 4 with toggling native ready
    rdy_mode = 1;
    send_aw(1'b0, 32'h200, 8'd3, AXI_BURST_INCR);
    for (int i = 0; i < 4; i++) send_beat(32'hB000_0000 + 32'(i), 4'hF, i == 3);
    wait_b("t2", 1'b0, AXI_RESP_OKAY);
    rdy_mode = 0;
    chk("t2_count", 64'(wr_addr_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_addr", 64'(wr_addr_q[i]), 64'(32'h200 + 32'(4 * i)));
      chk("t2_data", 64'(wr_data_q[i]), 64'(32'hB000_0000 + 32'(i)));
    end
    clear_writes();

    // WRAP burst: drained, SLVERR
    send_aw(1'b1, 32'h300, 8'd1, wrap_burst);
    send_beat(32'hC0, 4'hF, 1'b0);
    send_beat(32'hC1, 4'hF, 1'b1);
    wait_b("t3", 1'b1, AXI_RESP_SLVERR);
    chk("t3_count", 64'(wr_addr_q.size()), 64'd0);
    clear_writes();

    // FIXED burst: also rejected
    send_aw(1'b0, 32'h340, 8'd0, fixed_burst);
    send_beat(32'hC2, 4'hF, 1'b1);
    wait_b("t3f", 1'b0, AXI_RESP_SLVERR);
    chk("t3f_count", 64'(wr_addr_q.size()), 64'd0);
    clear_writes();

    // Early wlast on the second beat of a 4-beat burst, then a clean burst
    send_aw(1'b0, 32'h400, 8'd3, AXI_BURST_INCR);
    send_beat(32'hD0, 4'hF, 1'b0);
    send_beat(32'hD1, 4'hF, 1'b1);
    wait_b("t4", 1'b0, AXI_RESP_SLVERR);
    chk("t4_count", 64'(wr_addr_q.size()), 64'd2);
    chk("t4_addr0", 64'(wr_addr_q[0]), 64'h400);
    chk("t4_addr1", 64'(wr_addr_q[1]), 64'h404);
    clear_writes();
    send_aw(1'b1, 32'h500, 8'd0, AXI_BURST_INCR);
    send_beat(32'hD5, 4'hF, 1'b1);
    wait_b("t4b", 1'b1, AXI_RESP_OKAY);
    chk("t4b_count", 64'(wr_addr_q.size()), 64'd1);
    chk("t4b_addr", 64'(wr_addr_q[0]), 64'h500);
    clear_writes();

    // Zero strobe on beat 1 skips the native access but advances the address
    send_aw(1'b0, 32'h600, 8'd2, AXI_BURST_INCR);
    send_beat(32'hE0, 4'hF, 1'b0);
    send_beat(32'hE1, 4'h0, 1'b0);
    send_beat(32'hE2, 4'hF, 1'b1);
    wait_b("t5", 1'b0, AXI_RESP_OKAY);
    chk("t5_count", 64'(wr_addr_q.size()), 64'd2);
    chk("t5_addr0", 64'(wr_addr_q[0]), 64'h600);
    chk("t5_addr2", 64'(wr_addr_q[1]), 64'h608);
    chk("t5_data2", 64'(wr_data_q[1]), 64'hE2);
    clear_writes();

    // Missing wlast: overrun beat suppressed, then drained, SLVERR
    send_aw(1'b1, 32'h700, 8'd1, AXI_BURST_INCR);
    send_beat(32'hF0, 4'hF, 1'b0);
    send_beat(32'hF1, 4'hF, 1'b0);
    send_beat(32'hF2, 4'hF, 1'b1);
    wait_b("t6", 1'b1, AXI_RESP_SLVERR);
    chk("t6_count", 64'(wr_addr_q.size()), 64'd1);
    chk("t6_addr", 64'(wr_addr_q[0]), 64'h700);
    clear_writes();

    // Unaligned start is aligned down; partial strobes pass through
    send_aw(1'b0, 32'h803, 8'd0, AXI_BURST_INCR);
    send_beat(32'h1234_5678, 4'h3, 1'b1);
    wait_b("t8", 1'b0, AXI_RESP_OKAY);
    chk("t8_count", 64'(wr_addr_q.size()), 64'd1);
    chk("t8_addr", 64'(wr_addr_q[0]), 64'h800);
    chk("t8_strb", 64'(wr_strb_q[0]), 64'h3);
    clear_writes();

    // 4 KB crossing
    send_aw(1'b1, 32'hFF8, 8'd3, AXI_BURST_INCR);
    for (int i = 0; i < 4; i++) send_beat(32'h4000 + 32'(i), 4'hF, i == 3);
`ifdef AXI_WR_SLAVE_4K_CHECK_EN
    wait_b("t7", 1'b1, AXI_RESP_SLVERR);
    chk("t7_count", 64'(wr_addr_q.size()), 64'd0);
`else
    wait_b("t7", 1'b1, AXI_RESP_OKAY);
    chk("t7_count", 64'(wr_addr_q.size()), 64'd4);
    chk("t7_addr0", 64'(wr_addr_q[0]), 64'hFF8);
    chk("t7_addr1", 64'(wr_addr_q[1]), 64'hFFC);
    chk("t7_addr2", 64'(wr_addr_q[2]), 64'h1000);
    chk("t7_addr3", 64'(wr_addr_q[3]), 64'h1004);
`endif
    clear_writes();

    // Reset mid-burst: valid drops at the reset edge, no B response
    send_aw(1'b0, 32'h900, 8'd3, AXI_BURST_INCR);
    send_beat(32'h9000, 4'hF, 1'b0);
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    s_axi.wdata  = 32'h9001;
    s_axi.wstrb  = 4'hF;
    s_axi.wvalid = 1'b1;
    @(negedge clk);
    chk("t9_valid_pending", 64'(valid), 64'd1);
    chk("t9_wready_stall", 64'(s_axi.wready), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("t9_valid_dropped", 64'(valid), 64'd0);
    chk("t9_awready_rst", 64'(s_axi.awready), 64'd0);
    chk("t9_bvalid_rst", 64'(s_axi.bvalid), 64'd0);
    chk("t9_address_rst", 64'(address), 64'd0);
    s_axi.wvalid = 1'b0;
    rst          = 1'b1;
    rdy_mode     = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("t9_no_bvalid", 64'(s_axi.bvalid), 64'd0);
    chk("t9_awready_back", 64'(s_axi.awready), 64'd1);
    chk("t9_count", 64'(wr_addr_q.size()), 64'd1);
    clear_writes();
    send_aw(1'b1, 32'hA00, 8'd0, AXI_BURST_INCR);
    send_beat(32'hAA, 4'hF, 1'b1);
    wait_b("t9b", 1'b1, AXI_RESP_OKAY);
    chk("t9b_count", 64'(wr_addr_q.size()), 64'd1);
    chk("t9b_addr", 64'(wr_addr_q[0]), 64'hA00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
